// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types: the IF->ID packet, the imem request bundle and the reset fetch address.
`ifndef FETCH_RESET_PC
`define FETCH_RESET_PC 64'h0
`endif

package if_fetch_unit_pkg;

  localparam int XLEN_DEF = 64;
  localparam int ILEN_DEF = 32;
  localparam logic [XLEN_DEF-1:0] FETCH_RESET_PC = `FETCH_RESET_PC;

  typedef struct packed {
    logic [ILEN_DEF-1:0] inst;
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] npc;
    logic                valid;
  } IF_ID_PACKET;

  typedef struct packed {
    logic                valid;
    logic [XLEN_DEF-1:0] addr;
  } IMEM_REQ;

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// Synchronous FIFO with flush and occupancy count; head is visible combinationally, push/pop take effect at the edge.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_q];
  assign count_o    = cnt_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Sequential instruction fetch with credit-checked imem requests, in-order response queue and redirect flush.
// Redirect -> first new request 1 cycle; response -> packet valid 1 cycle; id_ready low stalls, requests stop when queue credits run out.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter int              ILEN      = ILEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = `FETCH_RESET_PC,
  parameter int              FQ_DEPTH  = 4,
  parameter int              MAX_OUTST = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_resp_valid,
  input  logic [ILEN-1:0]            imem_resp_inst,
  input  logic                       id_ready,
  output IF_ID_PACKET                if_packet_out,
  output logic [$clog2(FQ_DEPTH):0]  fq_count
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTST) + 1;
  localparam int PW = ILEN + XLEN;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   drop_q, drop_d;
  logic            credit_ok;
  logic            req_fire;
  logic            resp_fire;
  logic            resp_keep;
  logic            pkt_vld;
  logic            pkt_pop;
  logic [PW-1:0]   pq_head;
  logic [CW-1:0]   pq_count;
  logic [XLEN-1:0] tag_head;
  logic [OW-1:0]   tag_count;
  IMEM_REQ         req;

  // Every in-flight request already owns a queue slot, so a response can always be pushed.
  assign credit_ok = (32'(pq_count) + 32'(outst_q)) < 32'(FQ_DEPTH);

  always_comb begin
    req       = '0;
    req.valid = rst_n && !redirect_valid && (outst_q < OW'(MAX_OUTST)) && credit_ok;
    req.addr  = XLEN_DEF'(fetch_pc_q);
  end

  assign imem_req_valid = req.valid;
  assign imem_req_addr  = XLEN'(req.addr);

  assign req_fire  = req.valid && imem_req_ready;
  assign resp_fire = imem_resp_valid && (outst_q != '0);
  assign resp_keep = resp_fire && !redirect_valid && (drop_q == '0);
  assign pkt_vld   = (pq_count != '0) && !redirect_valid;
  assign pkt_pop   = pkt_vld && id_ready;

  always_comb begin
    outst_d    = outst_q + OW'(req_fire) - OW'(resp_fire);
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      // Everything still in flight after this edge belongs to the old path.
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      drop_d     = outst_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (resp_fire && (drop_q != '0)) drop_d = drop_q - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // Tags are never flushed: dropped responses still consume their tag in order.
  fetch_queue #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTST)
  ) u_tag_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (1'b0),
    .push_i     (req_fire),
    .push_dat_i (fetch_pc_q),
    .pop_i      (resp_fire),
    .head_dat_o (tag_head),
    .count_o    (tag_count)
  );

  fetch_queue #(
    .WIDTH (PW),
    .DEPTH (FQ_DEPTH)
  ) u_pkt_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect_valid),
    .push_i     (resp_keep),
    .push_dat_i ({imem_resp_inst, tag_head}),
    .pop_i      (pkt_pop),
    .head_dat_o (pq_head),
    .count_o    (pq_count)
  );

  assign fq_count = pq_count;

  always_comb begin
    if_packet_out       = '0;
    if_packet_out.inst  = ILEN_DEF'(pq_head[PW-1 -: ILEN]);
    if_packet_out.pc    = XLEN_DEF'(pq_head[XLEN-1:0]);
    if_packet_out.npc   = XLEN_DEF'(pq_head[XLEN-1:0] + XLEN'(4));
    if_packet_out.valid = pkt_vld;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!imem_resp_valid || (outst_q != '0));
      assert (tag_count == outst_q);
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised bench for if_fetch_unit with an epoch-tagged transaction model and directed literal checkpoints.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam int          FQ_DEPTH  = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [63:0] RESET_PC  = 64'h0;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_inst;
  logic        id_ready;
  IF_ID_PACKET if_packet_out;
  logic [2:0]  fq_count;

  if_fetch_unit #(
    .XLEN      (64),
    .ILEN      (32),
    .RESET_PC  (RESET_PC),
    .FQ_DEPTH  (FQ_DEPTH),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_inst  (imem_resp_inst),
    .id_ready        (id_ready),
    .if_packet_out   (if_packet_out),
    .fq_count        (fq_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } pkt_t;

  req_t        inflight[$];
  pkt_t        pktq[$];
  logic [63:0] acc_q[$];
  logic [63:0] pop_q[$];
  logic [63:0] m_pc;
  int          epoch, cyc;
  int          n_checks, n_fail;
  int          ready_pct, idr_pct, resp_pct, lat_min, lat_max;
  logic        last_rv, last_pv, last_pop;
  logic [63:0] last_addr;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [63:0] qat(input logic [63:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 64'hx;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic knobs(input int rp, input int ip, input int sp, input int lmin, input int lmax);
    ready_pct = rp; idr_pct = ip; resp_pct = sp; lat_min = lmin; lat_max = lmax;
  endtask

  // One clock cycle: drive at negedge, compare against the model, then advance the model at posedge.
  task automatic step(input bit redir, input logic [63:0] rpc);
    bit   rv_e, pv_e, req_fire, pop, resp;
    req_t r;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    imem_req_ready  = (int'($urandom_range(99)) < ready_pct);
    id_ready        = (int'($urandom_range(99)) < idr_pct);
    resp            = (inflight.size() > 0) && (inflight[0].due <= cyc) &&
                      (int'($urandom_range(99)) < resp_pct);
    imem_resp_valid = resp;
    imem_resp_inst  = resp ? inst_of(inflight[0].addr) : $urandom();
    #1;
    rv_e = !redir && (inflight.size() < MAX_OUTST) && ((pktq.size() + inflight.size()) < FQ_DEPTH);
    pv_e = (pktq.size() != 0) && !redir;
    chk("req_valid", 64'(imem_req_valid), 64'(rv_e));
    if (rv_e) chk("req_addr", imem_req_addr, m_pc);
    chk("pkt_valid", 64'(if_packet_out.valid), 64'(pv_e));
    if (pv_e) begin
      chk("pkt_pc", if_packet_out.pc, pktq[0].pc);
      chk("pkt_npc", if_packet_out.npc, pktq[0].pc + 64'd4);
      chk("pkt_inst", 64'(if_packet_out.inst), 64'(pktq[0].inst));
    end
    chk("fq_count", 64'(fq_count), 64'(pktq.size()));
    last_rv   = imem_req_valid;
    last_addr = imem_req_addr;
    last_pv   = if_packet_out.valid;
    last_pop  = if_packet_out.valid && id_ready;
    if (imem_req_valid && imem_req_ready) acc_q.push_back(imem_req_addr);
    if (last_pop) pop_q.push_back(if_packet_out.pc);
    req_fire = rv_e && imem_req_ready;
    pop      = pv_e && id_ready;
    @(posedge clk);
    if (pop) void'(pktq.pop_front());
    if (resp) begin
      r = inflight.pop_front();
      if (!redir && r.epoch == epoch) pktq.push_back('{r.addr, inst_of(r.addr)});
    end
    if (req_fire) begin
      inflight.push_back('{m_pc, epoch, cyc + int'($urandom_range(lat_max, lat_min))});
      m_pc = m_pc + 64'd4;
    end
    if (redir) begin
      m_pc = rpc & ~64'h3;
      epoch++;
      pktq.delete();
    end
    cyc++;
    @(negedge clk);
  endtask

  // Called at a negedge: reset lands between edges while a stale response is being offered.
  task automatic apply_reset(input string tag);
    #2;
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    imem_req_ready  = 1'b1;
    id_ready        = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_inst  = 32'hDEAD_BEEF;
    #1;
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    chk({tag, "_pkt_valid"}, 64'(if_packet_out.valid), 64'd0);
    chk({tag, "_fq_count"}, 64'(fq_count), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n           = 1'b1;
    imem_resp_valid = 1'b0;
    inflight.delete();
    pktq.delete();
    m_pc = RESET_PC;
    epoch++;
  endtask

  initial begin
    int          npop;
    bit          redir;
    logic [63:0] rpc;
    rst_n = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_inst = '0; id_ready = 1'b0;
    n_checks = 0; n_fail = 0; cyc = 0; epoch = 0; m_pc = RESET_PC;
    last_rv = 1'b0; last_pv = 1'b0; last_pop = 1'b0; last_addr = '0;
    knobs(100, 100, 100, 1, 1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    apply_reset("rst0");

    // Streaming: one packet per cycle once the pipe fills.
    npop = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0);
      if (i >= 8 && last_pop) npop++;
    end
    chk("stream_pops", 64'(npop), 64'd8);

    // Stall with decode blocked, then drain in order.
    apply_reset("rst1");
    knobs(100, 0, 100, 1, 1);
    for (int i = 0; i < 8; i++) step(1'b0, '0);
    chk("stall_fq_count", 64'(fq_count), 64'd4);
    chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
    chk("stall_head_pc", if_packet_out.pc, 64'h0);
    knobs(100, 100, 100, 1, 1);
    pop_q.delete();
    for (int i = 0; i < 10; i++) step(1'b0, '0);
    for (int k = 0; k < 6; k++) chk("drain_pc", qat(pop_q, k), 64'(k * 4));

    // Memory backpressure at 0x8.
    apply_reset("rst2");
    for (int i = 0; i < 2; i++) step(1'b0, '0);
    knobs(0, 100, 100, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0);
      chk("bp_req_valid", 64'(last_rv), 64'd1);
      chk("bp_addr", last_addr, 64'h8);
    end
    knobs(100, 100, 100, 1, 1);
    for (int i = 0; i < 4; i++) step(1'b0, '0);

    // Redirect with two requests in flight.
    apply_reset("rst3");
    knobs(100, 100, 100, 3, 3);
    for (int i = 0; i < 2; i++) step(1'b0, '0);
    acc_q.delete();
    pop_q.delete();
    step(1'b1, 64'h1002);
    chk("redir_cycle_req_valid", 64'(last_rv), 64'd0);
    for (int i = 0; i < 12; i++) step(1'b0, '0);
    chk("redir_first_req", qat(acc_q, 0), 64'h1000);
    chk("redir_first_pkt", qat(pop_q, 0), 64'h1000);

    // Redirect coinciding with a response and a ready decode.
    apply_reset("rst4");
    knobs(100, 100, 100, 1, 1);
    for (int i = 0; i < 6; i++) step(1'b0, '0);
    step(1'b1, 64'h2000);
    chk("sim_pkt_valid", 64'(last_pv), 64'd0);
    chk("sim_fq_after", 64'(fq_count), 64'd0);
    pop_q.delete();
    for (int i = 0; i < 6; i++) step(1'b0, '0);
    chk("sim_first_pkt", qat(pop_q, 0), 64'h2000);

    // Async reset with traffic in flight.
    knobs(100, 100, 100, 2, 2);
    for (int i = 0; i < 5; i++) step(1'b0, '0);
    apply_reset("midrst");
    acc_q.delete();
    for (int i = 0; i < 4; i++) step(1'b0, '0);
    chk("midrst_first_req", qat(acc_q, 0), RESET_PC);

    // Randomised traffic with redirects, pc wrap and one more reset.
    for (int blk = 0; blk < 15; blk++) begin
      knobs(int'($urandom_range(100, 20)), int'($urandom_range(100, 20)),
            int'($urandom_range(100, 30)), 1, int'($urandom_range(4, 1)));
      for (int i = 0; i < 200; i++) begin
        if (blk == 7 && i == 100) apply_reset("rand_rst");
        redir = (int'($urandom_range(99)) < 4);
        rpc   = (int'($urandom_range(9)) == 0) ? 64'hFFFF_FFFF_FFFF_FFF6 : {$urandom(), $urandom()};
        step(redir, redir ? rpc : 64'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
